// File: rtl/fetch_halt_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_halt_sequencer
//
// Program-counter / fetch sequencer for the single-cycle core. It drives the
// byte address into the 128x16 instruction RAM. The RAM returns the word in
// the same cycle. The sequencer gates datapath commit with EXEC, stops on the
// HALT opcode, restarts on a RESUME rising edge, and single-steps on STEP
// rising edges while in step mode.
//
// Ports
//   CLK        in   1   clock, all state on rising edge
//   RESET      in   1   asynchronous active-low reset
//   INSTR      in   16  IRAM read data for ADDR (same cycle)
//   STEP_MODE  in   1   1 = pause after every retired instruction
//   RESUME     in   1   level; rising edge restarts from HALTED
//   STEP       in   1   level; rising edge runs one instruction from PAUSED
//   BR_TAKEN   in   1   branch/jump taken this cycle
//   BR_TARGET  in   8   byte target address (bit 0 ignored)
//   ADDR       out  8   IRAM byte address (= PC)
//   EXEC       out  1   datapath may commit INSTR this cycle
//   HALTED     out  1   sequencer is in the HALTED state
//   RETIRED    out  16  saturating count of committed instructions
// ----------------------------------------------------------------------------
module fetch_halt_sequencer #(
    parameter logic [15:0] HALT_OP     = 16'h0001,
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] INSTR,
    input  logic        STEP_MODE,
    input  logic        RESUME,
    input  logic        STEP,
    input  logic        BR_TAKEN,
    input  logic [7:0]  BR_TARGET,
    output logic [7:0]  ADDR,
    output logic        EXEC,
    output logic        HALTED,
    output logic [15:0] RETIRED
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state_reg;
    logic [7:0]  pc_reg;
    logic [3:0]  boot_cnt_reg;
    logic [15:0] retired_reg;
    logic        resume_q_reg;
    logic        step_q_reg;

    logic        rise_resume;
    logic        rise_step;
    logic        is_halt;
    logic [7:0]  pc_next;

    assign rise_resume = RESUME & ~resume_q_reg;
    assign rise_step   = STEP & ~step_q_reg;
    assign is_halt     = (INSTR == HALT_OP);

    // Branch targets are word aligned; the low bit from the branch unit is dropped.
    assign pc_next = BR_TAKEN ? (BR_TARGET & 8'hFE) : (pc_reg + 8'd2);

    // EXEC depends on the current fetch word, so a HALT never commits and
    // never lets a same-cycle branch through.
    assign EXEC    = (state_reg == ST_RUN) && !is_halt;
    assign ADDR    = pc_reg;
    assign HALTED  = (state_reg == ST_HALTED);
    assign RETIRED = retired_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            boot_cnt_reg <= 4'd0;
            retired_reg  <= 16'd0;
            resume_q_reg <= 1'b0;
            step_q_reg   <= 1'b0;
        end else begin
            // Edge-detect history is tracked in every state so that a level
            // held across a state change never produces a late edge.
            resume_q_reg <= RESUME;
            step_q_reg   <= STEP;

            case (state_reg)
                ST_BOOT: begin
                    boot_cnt_reg <= boot_cnt_reg + 4'd1;
                    if (boot_cnt_reg == BOOT_LAST) begin
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (is_halt) begin
                        // PC stays on the HALT word so a resume can skip it.
                        state_reg <= ST_HALTED;
                    end else begin
                        pc_reg <= pc_next;
                        if (retired_reg != 16'hFFFF) begin
                            retired_reg <= retired_reg + 16'd1;
                        end
                        state_reg <= STEP_MODE ? ST_PAUSED : ST_RUN;
                    end
                end

                ST_HALTED: begin
                    if (rise_resume) begin
                        pc_reg    <= pc_reg + 8'd2;
                        state_reg <= ST_RUN;
                    end
                end

                ST_PAUSED: begin
                    if (rise_step) begin
                        state_reg <= ST_RUN;
                    end
                end

                default: begin
                    state_reg <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_halt_sequencer.sv
module tb_fetch_halt_sequencer;

    logic        CLK;
    logic        RESET;
    logic [15:0] INSTR;
    logic        STEP_MODE;
    logic        RESUME;
    logic        STEP;
    logic        BR_TAKEN;
    logic [7:0]  BR_TARGET;
    logic [7:0]  ADDR;
    logic        EXEC;
    logic        HALTED;
    logic [15:0] RETIRED;

    logic [15:0] iram [0:127];

    int n_checks;
    int n_fail;

    localparam logic [15:0] OP_HALT = 16'h0001;
    localparam logic [15:0] OP_SUB  = 16'h4123;
    localparam logic [15:0] OP_ADDI = 16'h5a07;
    localparam logic [15:0] OP_SB   = 16'h7c42;
    localparam logic [15:0] OP_NOP  = 16'h1234;

    fetch_halt_sequencer #(
        .HALT_OP    (16'h0001),
        .RESET_PC   (8'h00),
        .BOOT_CYCLES(2)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .INSTR    (INSTR),
        .STEP_MODE(STEP_MODE),
        .RESUME   (RESUME),
        .STEP     (STEP),
        .BR_TAKEN (BR_TAKEN),
        .BR_TARGET(BR_TARGET),
        .ADDR     (ADDR),
        .EXEC     (EXEC),
        .HALTED   (HALTED),
        .RETIRED  (RETIRED)
    );

    // Combinational IRAM read, word indexed by the byte address.
    assign INSTR = iram[ADDR[7:1]];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] addr_e,
                               input logic exec_e, input logic halted_e,
                               input logic [15:0] ret_e);
        check_val({tag, ".addr"},    32'(ADDR),    32'(addr_e));
        check_val({tag, ".exec"},    32'(EXEC),    32'(exec_e));
        check_val({tag, ".halted"},  32'(HALTED),  32'(halted_e));
        check_val({tag, ".retired"}, 32'(RETIRED), 32'(ret_e));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        STEP_MODE = 1'b0;
        RESUME    = 1'b0;
        STEP      = 1'b0;
        BR_TAKEN  = 1'b0;
        BR_TARGET = 8'h00;
        RESET     = 1'b1;

        for (int i = 0; i < 128; i++) iram[i] = OP_NOP;
        iram[8'h00 >> 1] = OP_SUB;
        iram[8'h02 >> 1] = OP_SUB;
        iram[8'h04 >> 1] = OP_ADDI;
        iram[8'h06 >> 1] = OP_SB;
        iram[8'h08 >> 1] = OP_HALT;
        iram[8'h18 >> 1] = OP_HALT;
        iram[8'h22 >> 1] = OP_HALT;

        // 1: reset for 3 cycles, then two boot cycles
        #3 RESET = 1'b0;
        tick(); tick(); tick();
        check_state("reset", 8'h00, 1'b0, 1'b0, 16'd0);
        RESET = 1'b1;
        check_val("boot0.exec", 32'(EXEC), 32'd0);
        tick();
        check_val("boot1.exec", 32'(EXEC), 32'd0);
        tick();
        check_state("boot_done", 8'h00, 1'b1, 1'b0, 16'd0);

        // 2: SUB,SUB,ADDI,SB then HALT at 0x08
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("prog%0d.addr", i), 32'(ADDR), 32'(2 * i));
            check_val($sformatf("prog%0d.exec", i), 32'(EXEC), 32'd1);
            tick();
        end
        check_state("halt_fetch", 8'h08, 1'b0, 1'b0, 16'd4);
        tick();
        check_state("halted1", 8'h08, 1'b0, 1'b1, 16'd4);

        // 3: RESUME held high -> one restart at 0x0A, halts again at 0x18
        RESUME = 1'b1;
        tick();
        check_state("resume1", 8'h0A, 1'b1, 1'b0, 16'd4);
        for (int i = 0; i < 7; i++) tick();
        check_state("halt2_fetch", 8'h18, 1'b0, 1'b0, 16'd11);
        tick();
        check_state("halted2", 8'h18, 1'b0, 1'b1, 16'd11);
        tick(); tick();
        check_state("halted2_hold", 8'h18, 1'b0, 1'b1, 16'd11);
        RESUME = 1'b0;
        tick();
        RESUME = 1'b1;
        tick();
        check_state("resume2", 8'h1A, 1'b1, 1'b0, 16'd11);
        RESUME = 1'b0;

        // 4: branch with odd target is aligned; branch on HALT is ignored
        BR_TAKEN  = 1'b1;
        BR_TARGET = 8'h21;
        tick();
        check_state("branch", 8'h20, 1'b1, 1'b0, 16'd12);
        BR_TAKEN = 1'b0;
        tick();
        BR_TAKEN  = 1'b1;
        BR_TARGET = 8'h40;
        check_state("br_on_halt", 8'h22, 1'b0, 1'b0, 16'd13);
        tick();
        check_state("br_halt_held", 8'h22, 1'b0, 1'b1, 16'd13);
        BR_TAKEN = 1'b0;

        // 5: step mode: one commit then PAUSED, three STEP pulses
        STEP_MODE = 1'b1;
        RESUME    = 1'b1;
        tick();
        RESUME = 1'b0;
        check_state("step_run", 8'h24, 1'b1, 1'b0, 16'd13);
        tick();
        check_state("paused", 8'h26, 1'b0, 1'b0, 16'd14);
        tick();
        check_state("paused_idle", 8'h26, 1'b0, 1'b0, 16'd14);
        for (int k = 0; k < 3; k++) begin
            STEP = 1'b1;
            tick();
            check_val($sformatf("step%0d.exec", k), 32'(EXEC), 32'd1);
            STEP = 1'b0;
            tick();
        end
        check_state("stepped3", 8'h2C, 1'b0, 1'b0, 16'd17);
        RESUME = 1'b1;
        tick();
        RESUME = 1'b0;
        tick();
        check_state("resume_in_pause", 8'h2C, 1'b0, 1'b0, 16'd17);

        // 6: jump to 0xFE, wrap to 0x00, then async reset mid-RUN
        STEP_MODE = 1'b0;
        STEP      = 1'b1;
        tick();
        STEP      = 1'b0;
        BR_TAKEN  = 1'b1;
        BR_TARGET = 8'hFE;
        tick();
        BR_TAKEN = 1'b0;
        check_state("at_fe", 8'hFE, 1'b1, 1'b0, 16'd18);
        tick();
        check_state("wrap", 8'h00, 1'b1, 1'b0, 16'd19);
        tick();
        check_val("pre_reset.addr", 32'(ADDR), 32'h02);
        #2 RESET = 1'b0;
        #1;
        check_state("async_reset", 8'h00, 1'b0, 1'b0, 16'd0);
        tick();
        RESET = 1'b1;
        check_val("reboot0.exec", 32'(EXEC), 32'd0);
        tick();
        check_val("reboot1.exec", 32'(EXEC), 32'd0);
        tick();
        check_state("reboot_done", 8'h00, 1'b1, 1'b0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
